// File: rtl/vga_pkg.sv
// Shared timing defaults, pixel types and RGB332 expansion for the VGA scanout path.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int unsigned DEF_FB_W       = 256;
    localparam int unsigned DEF_FB_H       = 256;
    localparam int unsigned DEF_X_OFF      = 192;
    localparam int unsigned DEF_Y_OFF      = 112;
    localparam int unsigned DEF_ADDR_WIDTH = $clog2(DEF_FB_W * DEF_FB_H);

    typedef logic [7:0] rgb332_t;

    localparam rgb332_t DEF_BORDER_COLOR = 8'h00;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Per-pixel control bits carried alongside the framebuffer read.
    typedef struct packed {
        logic active;
        logic in_win;
        logic hsync_n;
        logic vsync_n;
        logic frame_start;
    } scan_ctl_t;

    localparam scan_ctl_t CTL_RESET = '{
        active: 1'b0, in_win: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1, frame_start: 1'b0
    };

    function automatic rgb888_t expand_rgb332(input rgb332_t p);
        rgb888_t c;
        c.r = {p[7:5], p[7:5], p[7:6]};
        c.g = {p[4:2], p[4:2], p[4:3]};
        c.b = {p[1:0], p[1:0], p[1:0], p[1:0]};
        return c;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running h/v raster counters with active, sync, vblank and frame-start decodes.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW      = $clog2(H_TOTAL),
    localparam int unsigned VW      = $clog2(V_TOTAL)
) (
    input  logic          clock,
    input  logic          reset,
    output logic [HW-1:0] h_count,
    output logic [VW-1:0] v_count,
    output logic          active,
    output logic          hsync_n,
    output logic          vsync_n,
    output logic          vblank,
    output logic          frame_start_cond
);

    logic [HW-1:0] h_d, h_q;
    logic [VW-1:0] v_d, v_q;

    always_comb begin
        h_d = h_q + HW'(1);
        v_d = v_q;
        if (h_q == HW'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_count          = h_q;
    assign v_count          = v_q;
    assign active           = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
    assign hsync_n          = !((h_q >= HW'(H_ACTIVE + H_FP)) &&
                                (h_q < HW'(H_ACTIVE + H_FP + H_SYNC)));
    assign vsync_n          = !((v_q >= VW'(V_ACTIVE + V_FP)) &&
                                (v_q < VW'(V_ACTIVE + V_FP + V_SYNC)));
    assign vblank           = (v_q >= VW'(V_ACTIVE));
    assign frame_start_cond = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: raster timing, centred framebuffer window reads and a 2-stage pixel pipeline.
// Optional colour-bar source enabled by defining VGA_TEST_PATTERN_EN.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
    parameter int unsigned H_FP         = DEF_H_FP,
    parameter int unsigned H_SYNC       = DEF_H_SYNC,
    parameter int unsigned H_BP         = DEF_H_BP,
    parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
    parameter int unsigned V_FP         = DEF_V_FP,
    parameter int unsigned V_SYNC       = DEF_V_SYNC,
    parameter int unsigned V_BP         = DEF_V_BP,
    parameter int unsigned FB_W         = DEF_FB_W,
    parameter int unsigned FB_H         = DEF_FB_H,
    parameter int unsigned X_OFF        = DEF_X_OFF,
    parameter int unsigned Y_OFF        = DEF_Y_OFF,
    parameter rgb332_t     BORDER_COLOR = DEF_BORDER_COLOR,
    localparam int unsigned ADDR_WIDTH  = $clog2(FB_W * FB_H),
    localparam int unsigned HW          = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    localparam int unsigned VW          = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic                  clock,
    input  logic                  reset,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                  test_pattern,
`endif
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [7:0]            rdata,
    output logic [7:0]            vga_r,
    output logic [7:0]            vga_g,
    output logic [7:0]            vga_b,
    output logic                  vga_hsync,
    output logic                  vga_vsync,
    output logic                  vga_blank_n,
    output logic                  vblank,
    output logic                  frame_start
);

    logic [HW-1:0] h_count;
    logic [VW-1:0] v_count;
    logic          active, hsync_n, vsync_n, frame_start_cond, in_win;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clock            (clock),
        .reset            (reset),
        .h_count          (h_count),
        .v_count          (v_count),
        .active           (active),
        .hsync_n          (hsync_n),
        .vsync_n          (vsync_n),
        .vblank           (vblank),
        .frame_start_cond (frame_start_cond)
    );

    assign in_win = (h_count >= HW'(X_OFF)) && (h_count < HW'(X_OFF + FB_W)) &&
                    (v_count >= VW'(Y_OFF)) && (v_count < VW'(Y_OFF + FB_H));

    always_comb begin
        read_addr = '0;
        if (in_win) begin
            read_addr = ADDR_WIDTH'(v_count - VW'(Y_OFF)) * ADDR_WIDTH'(FB_W) +
                        ADDR_WIDTH'(h_count - HW'(X_OFF));
        end
    end

    scan_ctl_t ctl_d, ctl_q;
    rgb332_t   pix;
    rgb888_t   rgb_d, rgb_q;
    logic      hsync_d, hsync_q, vsync_d, vsync_q;
    logic      blank_n_d, blank_n_q, frame_start_d, frame_start_q;
`ifdef VGA_TEST_PATTERN_EN
    logic [HW-1:0] h_s1_q;
    logic [9:0]    bar_h;
`endif

    always_comb begin
        ctl_d.active      = active;
        ctl_d.in_win      = in_win;
        ctl_d.hsync_n     = hsync_n;
        ctl_d.vsync_n     = vsync_n;
        ctl_d.frame_start = frame_start_cond;

        // rdata lines up with ctl_q: both describe the pixel addressed one clock ago.
        pix = ctl_q.in_win ? rdata : BORDER_COLOR;
`ifdef VGA_TEST_PATTERN_EN
        bar_h = 10'(h_s1_q);
        if (test_pattern) begin
            pix = {bar_h[9:7], bar_h[9:7], bar_h[9:8]};
        end
`endif
        if (!ctl_q.active) begin
            pix = '0;
        end
        rgb_d         = expand_rgb332(pix);
        hsync_d       = ctl_q.hsync_n;
        vsync_d       = ctl_q.vsync_n;
        blank_n_d     = ctl_q.active;
        frame_start_d = ctl_q.frame_start;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctl_q         <= CTL_RESET;
            rgb_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            blank_n_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            ctl_q         <= ctl_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_n_q     <= blank_n_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_s1_q <= '0;
        end else begin
            h_s1_q <= h_count;
        end
    end
`endif

    assign vga_r       = rgb_q.r;
    assign vga_g       = rgb_q.g;
    assign vga_b       = rgb_q.b;
    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign vga_blank_n = blank_n_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout; vertical geometry is shrunk so whole frames fit the run,
// horizontal timing and window columns keep their full-size values.
`timescale 1ns / 1ps
module tb_vga_scanout;

    localparam int H_ACTIVE = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
    localparam int V_ACTIVE = 24, V_FP = 3, V_SYNC = 2, V_BP = 3;
    localparam int FB_W = 256, FB_H = 16, X_OFF = 192, Y_OFF = 4;
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME = H_TOT * V_TOT;
    localparam int AW = $clog2(FB_W * FB_H);

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] read_addr;
    logic [7:0]    rdata;
    logic [7:0]    vga_r, vga_g, vga_b;
    logic          vga_hsync, vga_vsync, vga_blank_n, vblank, frame_start;
`ifdef VGA_TEST_PATTERN_EN
    logic          test_pattern;
`endif

    vga_scanout #(
        .H_ACTIVE     (H_ACTIVE),
        .H_FP         (H_FP),
        .H_SYNC       (H_SYNC),
        .H_BP         (H_BP),
        .V_ACTIVE     (V_ACTIVE),
        .V_FP         (V_FP),
        .V_SYNC       (V_SYNC),
        .V_BP         (V_BP),
        .FB_W         (FB_W),
        .FB_H         (FB_H),
        .X_OFF        (X_OFF),
        .Y_OFF        (Y_OFF),
        .BORDER_COLOR (8'h00)
    ) dut (
        .clock        (clock),
        .reset        (reset),
`ifdef VGA_TEST_PATTERN_EN
        .test_pattern (test_pattern),
`endif
        .read_addr    (read_addr),
        .rdata        (rdata),
        .vga_r        (vga_r),
        .vga_g        (vga_g),
        .vga_b        (vga_b),
        .vga_hsync    (vga_hsync),
        .vga_vsync    (vga_vsync),
        .vga_blank_n  (vga_blank_n),
        .vblank       (vblank),
        .frame_start  (frame_start)
    );

    always #20 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int t;
    int saved_addr;
    bit saved_win;
    int fs_count, first_fs, second_fs, hs_fall, hs_rise, vs_fall, vs_rise;
    bit prev_hs, prev_vs;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0d: got %0h, expected %0h", name, t, act, exp);
        end
    endtask

    function automatic bit in_window(input int h, input int v);
        return h >= X_OFF && h < X_OFF + FB_W && v >= Y_OFF && v < Y_OFF + FB_H;
    endfunction

    // 3-bit channel spread over 0..255, 2-bit channel in steps of 85.
    function automatic int chan3(input int x);
        return x * 36 + x / 2;
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_r"}, int'(vga_r), 0);
        chk({tag, "_g"}, int'(vga_g), 0);
        chk({tag, "_b"}, int'(vga_b), 0);
        chk({tag, "_hsync"}, int'(vga_hsync), 1);
        chk({tag, "_vsync"}, int'(vga_vsync), 1);
        chk({tag, "_blank_n"}, int'(vga_blank_n), 0);
        chk({tag, "_frame_start"}, int'(frame_start), 0);
        chk({tag, "_vblank"}, int'(vblank), 0);
        chk({tag, "_read_addr"}, int'(read_addr), 0);
    endtask

    task automatic clear_tracking();
        fs_count = 0; first_fs = -1; second_fs = -1;
        hs_fall = -1; hs_rise = -1; vs_fall = -1; vs_rise = -1;
        prev_hs = 1'b1; prev_vs = 1'b1;
        saved_addr = 0; saved_win = 1'b0;
    endtask

    // Called at each falling edge with t = rising edges seen since reset release.
    task automatic cycle_body();
        int p, h, v, pix;
        bit act;
        // Synchronous RAM: word for last cycle's address; junk where the window was not hit.
        rdata = saved_win ? 8'(saved_addr) : 8'hC3;
        p = t % FRAME; h = p % H_TOT; v = p / H_TOT;
        saved_addr = int'(read_addr);
        saved_win = in_window(h, v);
        chk("read_addr", int'(read_addr), in_window(h, v) ? (v - Y_OFF) * FB_W + (h - X_OFF) : 0);
        chk("vblank", int'(vblank), (v >= V_ACTIVE) ? 1 : 0);
        if (t < 2) begin
            check_reset("refill");
        end else begin
            p = (t - 2) % FRAME; h = p % H_TOT; v = p / H_TOT;
            act = h < H_ACTIVE && v < V_ACTIVE;
            pix = !act ? 0 : in_window(h, v) ? ((v - Y_OFF) * FB_W + h - X_OFF) % 256 : 0;
            chk("vga_r", int'(vga_r), chan3(pix / 32));
            chk("vga_g", int'(vga_g), chan3((pix / 4) % 8));
            chk("vga_b", int'(vga_b), (pix % 4) * 85);
            chk("hsync", int'(vga_hsync), (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? 0 : 1);
            chk("vsync", int'(vga_vsync), (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? 0 : 1);
            chk("blank_n", int'(vga_blank_n), act ? 1 : 0);
            chk("frame_start", int'(frame_start), (h == 0 && v == 0) ? 1 : 0);
        end
        if (frame_start === 1'b1) begin
            fs_count++;
            if (first_fs < 0) first_fs = t;
            else if (second_fs < 0) second_fs = t;
        end
        if (prev_hs && !vga_hsync && hs_fall < 0) hs_fall = t;
        if (!prev_hs && vga_hsync && hs_fall >= 0 && hs_rise < 0) hs_rise = t;
        if (prev_vs && !vga_vsync && vs_fall < 0) vs_fall = t;
        if (!prev_vs && vga_vsync && vs_fall >= 0 && vs_rise < 0) vs_rise = t;
        prev_hs = vga_hsync;
        prev_vs = vga_vsync;
    endtask

    // Literal anchors, hand-derived for the geometry above.
    task automatic literal_checks();
        case (t)
            3391: chk("lit_addr_h191", int'(read_addr), 0);
            3392: chk("lit_addr_win_origin", int'(read_addr), 0);
            3393: begin
                chk("lit_h191_rgb", {8'h0, vga_r, vga_g, vga_b}, 0);
                chk("lit_h191_blank_n", int'(vga_blank_n), 1);
            end
            3394: chk("lit_origin_rgb", {8'h0, vga_r, vga_g, vga_b}, 0);
            3618: chk("lit_e0_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'hFF0000);
            3649: chk("lit_ff_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'hFFFFFF);
            3650: chk("lit_h448_rgb", {8'h0, vga_r, vga_g, vga_b}, 0);
            3902: begin
                chk("lit_blank_rgb", {8'h0, vga_r, vga_g, vga_b}, 0);
                chk("lit_blank_n", int'(vga_blank_n), 0);
                chk("lit_blank_hsync", int'(vga_hsync), 0);
            end
            4200: chk("lit_addr_264", int'(read_addr), 264);
            4202: chk("lit_px08_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h004900);
            default: ;
        endcase
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            t++;
            @(negedge clock);
            cycle_body();
            literal_checks();
        end
    endtask

    task automatic check_timing(input string tag);
        chk({tag, "_first_frame_start"}, first_fs, 2);
        chk({tag, "_hsync_start"}, hs_fall, 658);
        chk({tag, "_hsync_width"}, hs_rise - hs_fall, 96);
        chk({tag, "_vsync_start"}, vs_fall, 27 * 800 + 2);
        chk({tag, "_vsync_width"}, vs_rise - vs_fall, 1600);
    endtask

    initial begin
`ifdef VGA_TEST_PATTERN_EN
        test_pattern = 1'b0;
`endif
        reset = 1'b1;
        rdata = 8'h00;
        t = 0;
        clear_tracking();
        repeat (3) @(negedge clock);
        check_reset("por");

        reset = 1'b0;
        t = 0;
        cycle_body();
        run_cycles(FRAME + 200);
        check_timing("por");
        chk("por_second_frame_start", second_fs, 2 + 25600);
        chk("por_pulses_in_window", fs_count, 2);

        // Run into the second frame up to counter position (300, 10), then reset asynchronously.
        run_cycles(10 * H_TOT + 300 - 200);
        chk("pre_reset_addr", int'(read_addr), 6 * 256 + 108);
        reset = 1'b1;
        #1;
        check_reset("mid");
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_reset("held");
        end

        reset = 1'b0;
        t = 0;
        clear_tracking();
        cycle_body();
        run_cycles(23400);
        check_timing("rst");
        chk("rst_pulses", fs_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
